// File: rtl/pipe_pkg.sv
// Shared constants, state encoding and pipe-column generator for the scrolling pipe field.
package pipe_pkg;

    localparam int          GRID      = 16;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 as a Fibonacci feedback mask over bits 7,5,4,3
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [6:0]  SCORE_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FROZEN
    } state_t;

    // Out-of-range random values fold back into 0..GRID-gap so the gap never leaves the grid.
    function automatic logic [GRID-1:0] pipe_column(input logic [3:0] v, input int gap);
        logic [GRID-1:0] col;
        int              max_top;
        int              top;
        max_top = GRID - gap;
        top     = (int'(v) <= max_top) ? int'(v) : int'(v) - (max_top + 1);
        for (int r = 0; r < GRID; r++) begin
            col[r] = !((r >= top) && (r < top + gap));
        end
        return col;
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR supplying gap positions; steps only when a pipe is injected.
module pipe_lfsr
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] r_lfsr;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (advance) begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/pipe_scroller.sv
// Side-scrolling pipe field: shifts a 16x16 LED column array left on each tick and counts pipes passed.
module pipe_scroller
    import pipe_pkg::*;
#(
    parameter int GAP      = 4,
    parameter int SPACING  = 4,
    parameter int BIRD_COL = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      dead,
    output logic [GRID-1:0][GRID-1:0] red_out,
    output logic [6:0]                score,
    output logic                      running
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [GRID-1:0][GRID-1:0] r_cols;
    logic [GRID-1:0]           r_flags;
    logic [3:0]                r_space;
    logic [6:0]                r_score;
    logic [7:0]                w_lfsr;
    logic                      w_scroll;
    logic                      w_inject;
    logic [GRID-1:0]           w_new_col;
    logic                      w_unused_lfsr_hi;

    pipe_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_inject),
        .value   (w_lfsr)
    );

    assign w_unused_lfsr_hi = ^w_lfsr[7:4];

    // dead has priority over tick, so a collision cycle never shifts.
    assign w_scroll  = (r_state == ST_RUN) && tick && !dead;
    assign w_inject  = w_scroll && (r_space == 4'd0);
    assign w_new_col = w_inject ? pipe_column(w_lfsr[3:0], GAP) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state defaults to the current state first, so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_RUN;
            ST_RUN:    if (dead)  w_state_next = ST_FROZEN;
            ST_FROZEN: w_state_next = ST_FROZEN;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cols  <= '0;
            r_flags <= '0;
            r_space <= '0;
            r_score <= '0;
        end else if (w_scroll) begin
            for (int c = 0; c < GRID - 1; c++) begin
                r_cols[c] <= r_cols[c+1];
            end
            r_cols[GRID-1] <= w_new_col;
            r_flags        <= {w_inject, r_flags[GRID-1:1]};
            r_space        <= (r_space == 4'(SPACING - 1)) ? 4'd0 : r_space + 4'd1;
            if (r_flags[BIRD_COL] && (r_score != SCORE_MAX)) begin
                r_score <= r_score + 7'd1;
            end
        end
    end

    // Storage is column-major; the port is row-major.
    always_comb begin
        red_out = '0;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                red_out[r][c] = r_cols[c][r];
            end
        end
    end

    assign score   = r_score;
    assign running = (r_state == ST_RUN);

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with a pipe-list reference model feeding an expected-value queue.
module tb_pipe_scroller;

    localparam int GAP      = 4;
    localparam int SPACING  = 4;
    localparam int BIRD_COL = 2;

    typedef struct {
        logic [15:0][15:0] red;
        logic [6:0]        score;
        logic              running;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic              start = 1'b0;
    logic              dead = 1'b0;
    logic [15:0][15:0] red_out;
    logic [6:0]        score;
    logic              running;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    // reference model: a list of live pipes (column, gap top) rather than a bit array
    int         m_state;
    int         m_col[$];
    int         m_gap[$];
    int         m_space;
    logic [7:0] m_lfsr;
    int         m_score;

    pipe_scroller #(.GAP(GAP), .SPACING(SPACING), .BIRD_COL(BIRD_COL)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .start   (start),
        .dead    (dead),
        .red_out (red_out),
        .score   (score),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_col.delete();
        m_gap.delete();
        m_space = 0;
        m_lfsr  = 8'hA5;
        m_score = 0;
    endtask

    task automatic model_scroll();
        int nc[$];
        int ng[$];
        int v;
        for (int i = 0; i < m_col.size(); i++) begin
            if (m_col[i] == BIRD_COL && m_score < 99) m_score++;
            if (m_col[i] > 0) begin
                nc.push_back(m_col[i] - 1);
                ng.push_back(m_gap[i]);
            end
        end
        if (m_space == 0) begin
            v = int'(m_lfsr[3:0]);
            ng.push_back((v <= 16 - GAP) ? v : v - (17 - GAP));
            nc.push_back(15);
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
        m_space = (m_space + 1) % SPACING;
        m_col = nc;
        m_gap = ng;
    endtask

    task automatic model_update(input logic t, input logic s, input logic d, input logic r);
        if (r) begin
            model_reset();
        end else if (m_state == 0) begin
            if (s) m_state = 1;
        end else if (m_state == 1) begin
            if (d) m_state = 2;
            else if (t) model_scroll();
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.red = '0;
        for (int i = 0; i < m_col.size(); i++) begin
            for (int row = 0; row < 16; row++) begin
                if (row < m_gap[i] || row >= m_gap[i] + GAP) e.red[row][m_col[i]] = 1'b1;
            end
        end
        e.score   = 7'(m_score);
        e.running = (m_state == 1);
        return e;
    endfunction

    // Drives one cycle of inputs, queues the model's prediction, then compares after the edge.
    task automatic step(input logic t, input logic s, input logic d, input logic r);
        exp_t got;
        tick  = t;
        start = s;
        dead  = d;
        reset = r;
        model_update(t, s, d, r);
        sb_q.push_back(model_expect());
        @(posedge clk);
        @(negedge clk);
        got = sb_q.pop_front();
        check("red_out", 256'(red_out), 256'(got.red));
        check("score", 256'(score), 256'(got.score));
        check("running", 256'(running), 256'(got.running));
    endtask

    function automatic logic [15:0] column_of(input int c);
        logic [15:0] col;
        for (int r = 0; r < 16; r++) col[r] = red_out[r][c];
        return col;
    endfunction

    initial begin
        logic [255:0] held_red;
        logic [6:0]   held_score;
        model_reset();
        @(negedge clk);

        // reset, then idle ticks (dead ignored in IDLE)
        step(0, 0, 0, 1);
        check("reset_red", 256'(red_out), 256'(0));
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("idle_score", 256'(score), 256'(0));
        check("idle_running", 256'(running), 256'(0));

        // start, first pipe at column 15 with gap rows 5..8
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("first_col15", 256'(column_of(15)), 256'(16'hFE1F));
        check("first_col14", 256'(column_of(14)), 256'(0));

        // ticks 2..15: first pipe crosses the bird column on tick 15
        for (int i = 2; i <= 14; i++) step(1, 0, 0, 0);
        check("score_before", 256'(score), 256'(0));
        step(1, 0, 0, 0);
        check("score_after15", 256'(score), 256'(1));
        check("col2_empty", 256'(column_of(2)), 256'(0));

        // mixed ticking with idle gaps
        for (int i = 0; i < 24; i++) step((i % 3) != 1, 0, 0, 0);

        // tick and dead together: no shift, freeze
        held_red   = 256'(red_out);
        held_score = score;
        step(1, 0, 1, 0);
        check("frozen_noshift", 256'(red_out), held_red);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        check("frozen_red", 256'(red_out), held_red);
        check("frozen_score", 256'(score), 256'(held_score));

        // reset in FROZEN overrides everything, then a long run to saturate
        step(1, 1, 1, 1);
        step(0, 1, 0, 0);
        for (int i = 0; i < 820; i++) step(1, 0, 0, 0);
        check("score_sat", 256'(score), 256'(99));

        // freeze, then reset with every other input high
        step(1, 0, 1, 0);
        step(1, 1, 1, 1);
        check("final_red", 256'(red_out), 256'(0));
        check("final_score", 256'(score), 256'(0));
        check("final_running", 256'(running), 256'(0));
        step(1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 Parameter: GAP, 4, gap height in rows; legal range 2..8.
REQ-002 Parameter: SPACING, 4, column period between pipe columns; legal range 2..16.
REQ-003 Parameter: BIRD_COL, 2, column index the bird occupies; legal range 1..14.
REQ-004 Port: clk  input  1  system clock.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: tick  input  1  single-cycle scroll strobe.
REQ-007 Port: start  input  1  begin scrolling.
REQ-008 Port: dead  input  1  collision flag from the bird/pipe interaction block, sticky until reset.
REQ-009 Port: red_out  output  16x16  pipe LED array, [row][col]; row 0 is the top row, col 0 is the left edge.
REQ-010 Port: score  output  7  pipes passed, 0..99.
REQ-011 Port: running  output  1  high only in the RUN state.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and FROZEN.
REQ-013 IDLE SHALL go to RUN when start=1; dead SHALL be ignored in IDLE.
REQ-014 RUN SHALL go to FROZEN when dead=1; FROZEN SHALL be left only by reset.
REQ-015 Scrolling SHALL happen only in RUN on a cycle where tick=1 and dead=0; if tick and dead are both high, dead SHALL win and no shift SHALL occur.
REQ-016 On a scroll, every column c SHALL take the contents of column c+1, and column 0's contents SHALL be discarded.
REQ-017 On a scroll, column 15 SHALL be loaded with a pipe column when the spacing counter is 0; otherwise it SHALL be loaded with an empty column.
REQ-018 The spacing counter SHALL count 0..SPACING-1, advance on each scroll, and wrap from SPACING-1 to 0.
REQ-019 In a pipe column, every row SHALL be red except rows gap_top..gap_top+GAP-1.
REQ-020 gap_top SHALL be computed from v = lfsr[3:0] and MAXTOP = 16-GAP: gap_top = v when v <= MAXTOP, else gap_top = v-(MAXTOP+1).
REQ-021 The LFSR SHALL be 8 bits with taps x^8+x^6+x^5+x^4+1, SHALL be seeded with 8'hA5, and SHALL advance once per pipe injection, after its value has been used.
REQ-022 A 16-bit pipe-flag register SHALL shift in lockstep with the column array and mark which columns hold pipes.
REQ-023 score SHALL increment on a scroll whose pre-shift flag at BIRD_COL is 1, and SHALL saturate at 99.
REQ-024 red_out and score SHALL be registered, so a scroll SHALL be visible on the cycle after the tick.
REQ-025 In FROZEN, red_out and score SHALL hold their values, and the LFSR and spacing counter SHALL stop.

Reset
REQ-026 On reset, state SHALL be IDLE, red_out SHALL be all 0, the pipe flags SHALL be 0, the spacing counter SHALL be 0, the LFSR SHALL be 8'hA5, score SHALL be 0 and running SHALL be 0.
REQ-027 A reset asserted at any point, including mid-scroll or in FROZEN, SHALL take effect at the next clk edge and SHALL override tick, start and dead.

Structure
REQ-028 Package pipe_pkg SHALL hold the grid dimensions (16x16), the state enum, the LFSR seed, the tap mask and the score limit (99).
REQ-029 Sub-module pipe_lfsr SHALL contain the 8-bit LFSR, with clk, reset and advance inputs and an 8-bit value output.
REQ-030 The column array, pipe flags, spacing counter, score and FSM SHALL reside in pipe_scroller.

Verification
REQ-031 Scenario: reset, then 3 ticks with start=0 -> red_out all 0, score 0, running 0.
REQ-032 Scenario: reset, start, one tick -> column 15 = 16'hFE1F (gap rows 5..8), all other columns 0, running 1.
REQ-033 Scenario: continue ticking -> pipe columns spaced 4 apart, each new gap_top per REQ-020 from the advancing LFSR, all gap tops within 0..12.
REQ-034 Scenario: after start, 15 ticks -> score becomes 1 on the cycle after the 15th tick; the first pipe has left col 2.
REQ-035 Scenario: tick and dead high on the same cycle in RUN -> no shift, state FROZEN; further ticks leave red_out and score unchanged.
REQ-036 Scenario: force 200 pipe passes -> score saturates at 99; a reset while FROZEN returns all values to REQ-026 reset values.
